// File: rtl/spi_flash_cmd_seq.sv
// SPI flash command sequencer: expands read / page-program / sector-erase
// requests into ordered spi_drive operations (WREN, main op, RDSR polling)
// and forwards the user byte streams for the duration of the main op.
module spi_flash_cmd_seq #(
    parameter int unsigned P_CS_GAP   = 4,
    parameter int unsigned P_POLL_GAP = 16,
    parameter int unsigned P_POLL_MAX = 65535,
    parameter logic [7:0]  P_CMD_READ = 8'h03,
    parameter logic [7:0]  P_CMD_PP   = 8'h02,
    parameter logic [7:0]  P_CMD_SE   = 8'h20,
    parameter logic [7:0]  P_CMD_WREN = 8'h06,
    parameter logic [7:0]  P_CMD_RDSR = 8'h05
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [1:0]  i_cmd_type,
    input  logic [23:0] i_cmd_addr,
    input  logic [8:0]  i_cmd_len,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [7:0]  i_wr_data,
    output logic        o_wr_req,
    output logic [7:0]  o_rd_data,
    output logic        o_rd_valid,
    output logic        o_done,
    output logic        o_error,
    output logic [31:0] o_op_data,
    output logic [1:0]  o_op_type,
    output logic [15:0] o_op_len,
    output logic [15:0] o_clk_len,
    output logic        o_op_valid,
    input  logic        i_op_ready,
    output logic [7:0]  o_drv_wr_data,
    input  logic        i_drv_wr_req,
    input  logic [7:0]  i_drv_rd_data,
    input  logic        i_drv_rd_valid
);
    localparam int unsigned LP_PW = $clog2(P_POLL_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_GAP, S_ISSUE, S_WAIT_LO, S_WAIT_HI, S_EVAL, S_POLL_DLY, S_DONE
    } state_t;

    // Position within the command's op sequence.
    typedef enum logic [1:0] {OP_WREN, OP_MAIN, OP_RDSR} op_t;

    state_t            r_state;
    state_t            w_next;
    op_t               r_op;
    logic [15:0]       r_cnt;
    logic [1:0]        r_type;
    logic [23:0]       r_addr;
    logic [8:0]        r_len;
    logic              r_bad;
    logic              r_err;
    logic [LP_PW-1:0]  r_poll;
    logic [7:0]        r_status;
    logic [7:0]        r_rd_data;
    logic              r_rd_valid;

    logic              w_accept;
    logic              w_cmd_bad;
    logic              w_in_op;
    logic              w_rd_fwd;
    logic              w_wr_fwd;
    logic              w_stat_cap;
    logic [LP_PW-1:0]  w_poll_inc;
    logic              w_poll_last;
    logic [15:0]       w_xfer_clks;

    assign w_accept    = i_cmd_valid & (r_state == S_IDLE);
    // Erase ignores the length; read/program need 1..256 bytes; type 3 is reserved.
    assign w_cmd_bad   = (i_cmd_type == 2'd3) |
                         ((i_cmd_type != 2'd2) & ((i_cmd_len == 9'd0) | (i_cmd_len > 9'd256)));
    assign w_in_op     = (r_state == S_ISSUE) | (r_state == S_WAIT_LO) | (r_state == S_WAIT_HI);
    assign w_rd_fwd    = w_in_op & (r_op == OP_MAIN) & (r_type == 2'd0);
    assign w_wr_fwd    = w_in_op & (r_op == OP_MAIN) & (r_type == 2'd1);
    assign w_stat_cap  = w_in_op & (r_op == OP_RDSR);
    assign w_poll_inc  = r_poll + LP_PW'(1);
    assign w_poll_last = (w_poll_inc == LP_PW'(P_POLL_MAX));
    assign w_xfer_clks = 16'd32 + {4'd0, r_len, 3'd0};

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state decode: every op runs GAP -> ISSUE -> WAIT_LO -> WAIT_HI -> EVAL.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (w_accept) w_next = w_cmd_bad ? S_EVAL : S_GAP;
            S_GAP:      if (r_cnt == 16'(P_CS_GAP - 1)) w_next = S_ISSUE;
            S_ISSUE:    if (i_op_ready) w_next = S_WAIT_LO;
            S_WAIT_LO:  if (!i_op_ready) w_next = S_WAIT_HI;
            S_WAIT_HI:  if (i_op_ready) w_next = S_EVAL;
            S_EVAL: begin
                if (r_bad) w_next = S_DONE;
                else begin
                    case (r_op)
                        OP_WREN: w_next = S_GAP;
                        OP_MAIN: w_next = (r_type == 2'd0) ? S_DONE : S_GAP;
                        default: w_next = !r_status[0] ? S_DONE :
                                          (w_poll_last ? S_DONE : S_POLL_DLY);
                    endcase
                end
            end
            S_POLL_DLY: if (r_cnt == 16'(P_POLL_GAP - 1)) w_next = S_GAP;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Output decode: op fields are driven only while the op is being offered.
    always_comb begin
        o_cmd_ready   = (r_state == S_IDLE);
        o_done        = (r_state == S_DONE);
        o_error       = (r_state == S_DONE) & r_err;
        o_wr_req      = i_drv_wr_req & w_wr_fwd;
        o_drv_wr_data = w_wr_fwd ? i_wr_data : 8'd0;
        o_op_valid    = 1'b0;
        o_op_data     = 32'd0;
        o_op_type     = 2'd0;
        o_op_len      = 16'd0;
        o_clk_len     = 16'd0;
        if (r_state == S_ISSUE) begin
            o_op_valid = 1'b1;
            case (r_op)
                OP_WREN: begin
                    o_op_data = {24'd0, P_CMD_WREN};
                    o_op_type = 2'd0; o_op_len = 16'd8; o_clk_len = 16'd8;
                end
                OP_RDSR: begin
                    o_op_data = {24'd0, P_CMD_RDSR};
                    o_op_type = 2'd2; o_op_len = 16'd8; o_clk_len = 16'd16;
                end
                default: begin
                    o_op_len = 16'd32;
                    case (r_type)
                        2'd0: begin
                            o_op_data = {P_CMD_READ, r_addr}; o_op_type = 2'd2; o_clk_len = w_xfer_clks;
                        end
                        2'd1: begin
                            o_op_data = {P_CMD_PP, r_addr}; o_op_type = 2'd1; o_clk_len = w_xfer_clks;
                        end
                        default: begin
                            o_op_data = {P_CMD_SE, r_addr}; o_op_type = 2'd0; o_clk_len = 16'd32;
                        end
                    endcase
                end
            endcase
        end
    end

    // Sequence control: dwell counter, op position, poll count and error flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt  <= 16'd0;
            r_op   <= OP_WREN;
            r_type <= 2'd0;
            r_bad  <= 1'b0;
            r_err  <= 1'b0;
            r_poll <= '0;
        end else begin
            r_cnt <= ((w_next != r_state) || (r_state == S_IDLE)) ? 16'd0 : r_cnt + 16'd1;
            if (w_accept) begin
                r_type <= i_cmd_type;
                r_bad  <= w_cmd_bad;
                r_err  <= w_cmd_bad;
                r_poll <= '0;
                r_op   <= (i_cmd_type == 2'd1 || i_cmd_type == 2'd2) ? OP_WREN : OP_MAIN;
            end else if (r_state == S_EVAL && !r_bad) begin
                case (r_op)
                    OP_WREN: r_op <= OP_MAIN;
                    OP_MAIN: r_op <= OP_RDSR;
                    default: if (r_status[0]) begin
                        r_poll <= w_poll_inc;
                        if (w_poll_last) r_err <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Command payload and last status byte; cleared status avoids a stale WIP.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_addr   <= i_cmd_addr;
            r_len    <= i_cmd_len;
            r_status <= 8'd0;
        end else if (w_stat_cap && i_drv_rd_valid) begin
            r_status <= i_drv_rd_data;
        end
    end

    // Read-data forwarding, one register stage, only for the READ op.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_data  <= 8'd0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= i_drv_rd_valid & w_rd_fwd;
            if (i_drv_rd_valid && w_rd_fwd) r_rd_data <= i_drv_rd_data;
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;

endmodule

// File: tb/tb_spi_flash_cmd_seq.sv
// Bench for spi_flash_cmd_seq: a behavioural spi_drive model plus a user-side
// byte source; expected ops, bytes and completions are queued by the stimulus
// and consumed by independent monitors.
module tb_spi_flash_cmd_seq;
    localparam int P_CS_GAP   = 4;
    localparam int P_POLL_GAP = 16;
    localparam int P_POLL_MAX = 4;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [1:0]  i_cmd_type = '0;
    logic [23:0] i_cmd_addr = '0;
    logic [8:0]  i_cmd_len = '0;
    logic        i_cmd_valid = 1'b0;
    logic        o_cmd_ready;
    logic [7:0]  i_wr_data = '0;
    logic        o_wr_req;
    logic [7:0]  o_rd_data;
    logic        o_rd_valid;
    logic        o_done;
    logic        o_error;
    logic [31:0] o_op_data;
    logic [1:0]  o_op_type;
    logic [15:0] o_op_len;
    logic [15:0] o_clk_len;
    logic        o_op_valid;
    logic        i_op_ready = 1'b1;
    logic [7:0]  o_drv_wr_data;
    logic        i_drv_wr_req = 1'b0;
    logic [7:0]  i_drv_rd_data = '0;
    logic        i_drv_rd_valid = 1'b0;

    spi_flash_cmd_seq #(
        .P_CS_GAP(P_CS_GAP), .P_POLL_GAP(P_POLL_GAP), .P_POLL_MAX(P_POLL_MAX)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_cmd_type(i_cmd_type), .i_cmd_addr(i_cmd_addr), .i_cmd_len(i_cmd_len),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_wr_data(i_wr_data), .o_wr_req(o_wr_req),
        .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
        .o_done(o_done), .o_error(o_error),
        .o_op_data(o_op_data), .o_op_type(o_op_type), .o_op_len(o_op_len),
        .o_clk_len(o_clk_len), .o_op_valid(o_op_valid), .i_op_ready(i_op_ready),
        .o_drv_wr_data(o_drv_wr_data), .i_drv_wr_req(i_drv_wr_req),
        .i_drv_rd_data(i_drv_rd_data), .i_drv_rd_valid(i_drv_rd_valid)
    );

    always #5 i_clk = ~i_clk;

    typedef struct { logic [31:0] data; logic [1:0] typ; logic [15:0] op_len; logic [15:0] clk_len; } op_s;
    typedef struct { logic err; int cyc; } done_s;

    op_s        exp_op_q[$];
    done_s      exp_done_q[$];
    logic [7:0] exp_rd_q[$], exp_wr_q[$], user_q[$], flash_q[$], status_q[$];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    logic drv_in_pp = 1'b0;

    always @(posedge i_clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name, input logic [63:0] act);
        n_chk++;
        n_err++;
        $display("FAIL %s: got %0h where none was expected (cycle %0d)", name, act, cyc);
    endtask

    function automatic void push_op(logic [31:0] d, logic [1:0] t, logic [15:0] ol, logic [15:0] cl);
        op_s o;
        o.data = d; o.typ = t; o.op_len = ol; o.clk_len = cl;
        exp_op_q.push_back(o);
    endfunction

    function automatic void clear_all();
        exp_op_q.delete(); exp_done_q.delete(); exp_rd_q.delete();
        exp_wr_q.delete(); user_q.delete(); flash_q.delete(); status_q.delete();
    endfunction

    // spi_drive model: accepts an op, drops ready, moves its data bytes, raises ready.
    initial begin : drv_model
        int st, rem, ph, last_done, gap, min_gap;
        logic cur_rdsr, last_rdsr;
        logic [1:0] cur_type;
        op_s e;
        st = 0; rem = 0; ph = 0; last_done = -1; last_rdsr = 1'b0; cur_rdsr = 1'b0; cur_type = '0;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                i_op_ready = 1'b1; i_drv_rd_valid = 1'b0; i_drv_wr_req = 1'b0;
                st = 0; ph = 0; last_done = -1; drv_in_pp = 1'b0;
                continue;
            end
            case (st)
                0: if (o_op_valid) begin
                    cur_rdsr = (o_op_data == 32'h05) && (o_op_len == 16'd8);
                    cur_type = o_op_type;
                    if (exp_op_q.size() == 0) flag("op_unexpected", o_op_data);
                    else begin
                        e = exp_op_q.pop_front();
                        check("op_data", o_op_data, e.data);
                        check("op_type", o_op_type, e.typ);
                        check("op_len", o_op_len, e.op_len);
                        check("clk_len", o_clk_len, e.clk_len);
                    end
                    if (last_done >= 0) begin
                        gap = cyc - last_done;
                        min_gap = (cur_rdsr && last_rdsr) ? P_POLL_GAP : P_CS_GAP;
                        n_chk++;
                        if (gap < min_gap) begin
                            n_err++;
                            $display("FAIL op_gap: got %0d cycles expected at least %0d", gap, min_gap);
                        end
                    end
                    rem = (int'(o_clk_len) - int'(o_op_len)) / 8;
                    if (rem < 0 || rem > 300) rem = 0;
                    st = 1;
                end
                1: begin
                    check("op_valid_drop", o_op_valid, 1'b0);
                    i_op_ready = 1'b0; ph = 0; st = 2;
                    drv_in_pp = (cur_type == 2'd1);
                end
                default: if (ph == 0) begin
                    if (rem > 0) begin
                        rem--; ph = 1;
                        if (cur_type == 2'd2) begin
                            i_drv_rd_valid = 1'b1;
                            if (cur_rdsr) i_drv_rd_data = (status_q.size() != 0) ? status_q.pop_front() : 8'h00;
                            else          i_drv_rd_data = (flash_q.size() != 0) ? flash_q.pop_front() : 8'hFF;
                        end else if (cur_type == 2'd1) i_drv_wr_req = 1'b1;
                    end else begin
                        i_op_ready = 1'b1; st = 0; drv_in_pp = 1'b0;
                        last_done = cyc; last_rdsr = cur_rdsr;
                    end
                end else begin
                    i_drv_rd_valid = 1'b0;
                    if (i_drv_wr_req) begin
                        i_drv_wr_req = 1'b0;
                        if (exp_wr_q.size() == 0) flag("wr_unexpected", o_drv_wr_data);
                        else check("wr_byte", o_drv_wr_data, exp_wr_q.pop_front());
                    end
                    ph = 0;
                end
            endcase
        end
    end

    // User program-byte source: answers each o_wr_req with the next byte.
    initial begin : user_src
        forever begin
            @(negedge i_clk);
            #1;
            if (o_wr_req) i_wr_data = (user_q.size() != 0) ? user_q.pop_front() : 8'hEE;
        end
    end

    // Read-data and completion monitor.
    initial begin : mon
        logic ready_pend;
        done_s d;
        ready_pend = 1'b0;
        forever begin
            @(negedge i_clk);
            if (ready_pend) begin
                check("ready_after_done", o_cmd_ready, 1'b1);
                ready_pend = 1'b0;
            end
            if (o_rd_valid) begin
                if (exp_rd_q.size() == 0) flag("rd_unexpected", o_rd_data);
                else check("rd_byte", o_rd_data, exp_rd_q.pop_front());
            end
            if (o_error && !o_done) flag("error_without_done", o_error);
            if (o_done) begin
                if (exp_done_q.size() == 0) flag("done_unexpected", o_error);
                else begin
                    d = exp_done_q.pop_front();
                    check("done_error", o_error, d.err);
                    if (d.cyc >= 0) check("done_cycle", cyc, d.cyc);
                    ready_pend = 1'b1;
                end
            end
        end
    end

    task automatic send_cmd(input logic [1:0] t, input logic [23:0] a, input logic [8:0] l,
                            input logic err, input logic timed);
        int g;
        done_s d;
        g = 0;
        while (!o_cmd_ready && g < 2000) begin @(negedge i_clk); g++; end
        if (!o_cmd_ready) flag("cmd_ready_timeout", o_cmd_ready);
        i_cmd_type = t; i_cmd_addr = a; i_cmd_len = l; i_cmd_valid = 1'b1;
        d.err = err; d.cyc = timed ? cyc + 2 : -1;
        exp_done_q.push_back(d);
        @(negedge i_clk);
        i_cmd_valid = 1'b0;
        check("cmd_ready_drop", o_cmd_ready, 1'b0);
    endtask

    task automatic wait_done(input string name);
        int g;
        g = 0;
        while (exp_done_q.size() != 0 && g < 3000) begin @(negedge i_clk); g++; end
        if (exp_done_q.size() != 0) flag({name, "_done_timeout"}, exp_done_q.size());
        repeat (2) @(negedge i_clk);
        check({name, "_ops_left"}, exp_op_q.size(), 0);
        check({name, "_bytes_left"}, exp_rd_q.size() + exp_wr_q.size() + flash_q.size() + status_q.size(), 0);
        clear_all();
    endtask

    initial begin : stim
        int g;
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int g;
        repeat (3) @(negedge i_clk);
        #1;
        check("rst_ctrl", {o_cmd_ready, o_op_valid, o_done, o_error, o_wr_req, o_rd_valid}, 6'b100000);
        check("rst_op_data", o_op_data, 32'd0);
        check("rst_op_fields", {o_op_type, o_op_len, o_clk_len}, 34'd0);
        check("rst_bytes", {o_rd_data, o_drv_wr_data}, 16'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);

        // Read 4 bytes at 0x000100.
        push_op(32'h03000100, 2'd2, 16'd32, 16'd64);
        foreach (flash_q[i]) ;
        flash_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        exp_rd_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        send_cmd(2'd0, 24'h000100, 9'd4, 1'b0, 1'b0);
        wait_done("read4");

        // Program 2 bytes at 0x001000, ready on first poll.
        push_op(32'h00000006, 2'd0, 16'd8, 16'd8);
        push_op(32'h02001000, 2'd1, 16'd32, 16'd48);
        push_op(32'h00000005, 2'd2, 16'd8, 16'd16);
        user_q = '{8'h5A, 8'hC3};
        exp_wr_q = '{8'h5A, 8'hC3};
        status_q = '{8'h00};
        send_cmd(2'd1, 24'h001000, 9'd2, 1'b0, 1'b0);
        wait_done("program2");

        // Erase at 0x020000 (length ignored), WIP for three polls; only bit0 matters.
        push_op(32'h00000006, 2'd0, 16'd8, 16'd8);
        push_op(32'h20020000, 2'd0, 16'd32, 16'd32);
        for (int i = 0; i < 4; i++) push_op(32'h00000005, 2'd2, 16'd8, 16'd16);
        status_q = '{8'h01, 8'h03, 8'h81, 8'h02};
        send_cmd(2'd2, 24'h020000, 9'd0, 1'b0, 1'b0);
        wait_done("erase_poll");

        // Erase with WIP stuck: poll limit of 4 gives an error.
        push_op(32'h00000006, 2'd0, 16'd8, 16'd8);
        push_op(32'h20123000, 2'd0, 16'd32, 16'd32);
        for (int i = 0; i < 4; i++) push_op(32'h00000005, 2'd2, 16'd8, 16'd16);
        status_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        send_cmd(2'd2, 24'h123000, 9'd16, 1'b1, 1'b0);
        wait_done("erase_timeout");

        // Rejected commands: no driver ops, done+error two cycles after accept.
        send_cmd(2'd0, 24'h000010, 9'd0, 1'b1, 1'b1);
        wait_done("read_len0");
        send_cmd(2'd3, 24'h000020, 9'd5, 1'b1, 1'b1);
        wait_done("type3");
        send_cmd(2'd1, 24'h000030, 9'd257, 1'b1, 1'b1);
        wait_done("program_len257");

        // Full 256-byte read: longest clk_len.
        push_op(32'h03ABCD00, 2'd2, 16'd32, 16'd2080);
        for (int i = 0; i < 256; i++) begin
            flash_q.push_back(8'(i * 7 + 3));
            exp_rd_q.push_back(8'(i * 7 + 3));
        end
        send_cmd(2'd0, 24'hABCD00, 9'd256, 1'b0, 1'b0);
        wait_done("read256");

        // Reset in the middle of a page program.
        push_op(32'h00000006, 2'd0, 16'd8, 16'd8);
        push_op(32'h02000040, 2'd1, 16'd32, 16'd96);
        for (int i = 0; i < 8; i++) begin
            user_q.push_back(8'h10 + 8'(i));
            exp_wr_q.push_back(8'h10 + 8'(i));
        end
        send_cmd(2'd1, 24'h000040, 9'd8, 1'b0, 1'b0);
        g = 0;
        while (!drv_in_pp && g < 500) begin @(negedge i_clk); g++; end
        if (!drv_in_pp) flag("pp_start_timeout", drv_in_pp);
        repeat (4) @(negedge i_clk);
        i_rst = 1'b1;
        clear_all();
        #1;
        check("midrst_ctrl", {o_cmd_ready, o_op_valid, o_done, o_error, o_wr_req, o_rd_valid}, 6'b100000);
        check("midrst_op", {o_op_data, o_op_type, o_op_len, o_clk_len}, 66'd0);
        check("midrst_bytes", {o_rd_data, o_drv_wr_data}, 16'd0);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);

        // Normal read after the abort.
        push_op(32'h03000000, 2'd2, 16'd32, 16'd40);
        flash_q = '{8'h7E};
        exp_rd_q = '{8'h7E};
        send_cmd(2'd0, 24'h000000, 9'd1, 1'b0, 1'b0);
        wait_done("read_after_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
